// File: rtl/iomem_copy_master.sv
// Word-copy bus master for a PicoRV32-style iomem port.
// Each word is read from the source, then written to the destination. A
// one-cycle valid-low gap follows every accepted access. An access that
// stalls too long aborts the whole copy with a sticky error flag.
module iomem_copy_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             iomem_valid,
    input  logic             iomem_ready,
    output logic [3:0]       iomem_wstrb,
    output logic [31:0]      iomem_addr,
    output logic [31:0]      iomem_wdata,
    input  logic [31:0]      iomem_rdata
);

    // The stall counter only has to reach TIMEOUT, because the copy aborts there.
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // State and datapath registers; reset returns to an idle, quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and bus outputs, decoded from the current state only.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        tmo_d       = '0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    src_d = src_addr & ~32'h3;
                    dst_d = dst_addr & ~32'h3;
                    cnt_d = len;
                    // An empty copy goes through WR_GAP with a zero count.
                    // That state makes no bus access and leads to FIN, so
                    // done still comes two cycles after start.
                    state_d = (len != '0) ? RD : WR_GAP;
                end
            end

            RD: begin
                iomem_valid = 1'b1;
                iomem_addr  = src_q;
                if (iomem_ready) begin
                    data_d  = iomem_rdata;
                    src_d   = src_q + 32'd4;
                    state_d = RD_GAP;
                end else if (tmo_q == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            RD_GAP: begin
                state_d = WR;
            end

            WR: begin
                iomem_valid = 1'b1;
                iomem_wstrb = 4'hF;
                iomem_addr  = dst_q;
                iomem_wdata = data_q;
                if (iomem_ready) begin
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = WR_GAP;
                end else if (tmo_q == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            WR_GAP: begin
                state_d = (cnt_q != '0) ? RD : FIN;
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);
    assign error = err_q;

endmodule

// File: tb/tb_iomem_copy_master.sv
// Self-checking bench for iomem_copy_master: a table of copy jobs plus
// hand-written timeout, stray-ready and reset-during-write sequences.
module tb_iomem_copy_master;

    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    logic        respReady;
    logic        strayReady;
    logic [31:0] respData;
    int          waits;
    logic        neverReady;

    int totalChecks;
    int badChecks;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          waits;
        int          midStart;
        int          expLat;
        logic        expErr;
    } job_t;

    acc_t        accLog[$];
    logic [31:0] mem[bit [31:0]];

    iomem_copy_master #(
        .TIMEOUT(TMO),
        .LEN_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata)
    );

    assign iomem_ready = respReady | strayReady;
    assign iomem_rdata = respData;

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Words that were never written hold a fixed, address-derived pattern.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] readMem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Responder: waits a programmable number of cycles per access, then
    // strobes ready. It checks that requests hold steady while stalled and
    // that valid drops for a cycle after every ready.
    initial begin : responder
        logic [31:0] hAddr;
        logic [31:0] hWdata;
        logic [3:0]  hWstrb;
        logic        inTxn;
        logic        prevReady;
        int          stall;
        respReady = 1'b0;
        respData  = 32'h0;
        inTxn     = 1'b0;
        prevReady = 1'b0;
        stall     = 0;
        hAddr     = 32'h0;
        hWdata    = 32'h0;
        hWstrb    = 4'h0;
        forever begin
            @(negedge clk);
            if (prevReady) checkOutput("gapAfterReady", {31'h0, iomem_valid}, 32'h0);
            prevReady = 1'b0;
            if (iomem_valid) begin
                if (!inTxn) begin
                    hAddr  = iomem_addr;
                    hWdata = iomem_wdata;
                    hWstrb = iomem_wstrb;
                    inTxn  = 1'b1;
                end else begin
                    checkOutput("holdAddr", iomem_addr, hAddr);
                    checkOutput("holdWdata", iomem_wdata, hWdata);
                    checkOutput("holdWstrb", {28'h0, iomem_wstrb}, {28'h0, hWstrb});
                end
                if (!neverReady && stall == waits) begin
                    respReady = 1'b1;
                    if (iomem_wstrb == 4'hF) begin
                        mem[iomem_addr] = iomem_wdata;
                        accLog.push_back('{iomem_addr, 1'b1, iomem_wdata});
                    end else begin
                        respData = readMem(iomem_addr);
                        accLog.push_back('{iomem_addr, 1'b0, respData});
                    end
                    stall     = 0;
                    inTxn     = 1'b0;
                    prevReady = 1'b1;
                end else begin
                    respReady = 1'b0;
                    stall++;
                end
            end else begin
                respReady = 1'b0;
                stall     = 0;
                inTxn     = 1'b0;
            end
        end
    end

    // Runs one copy job from a negedge and checks latency, flags, bus log and memory.
    task automatic applyStimulus(input int idx, input job_t j);
        int   lat;
        int   validCnt;
        logic gotDone;
        logic errAtDone;
        int   expValid;
        accLog.delete();
        waits    = j.waits;
        start    = 1'b1;
        src_addr = j.src;
        dst_addr = j.dst;
        len      = 16'(j.len);
        lat       = 0;
        validCnt  = 0;
        gotDone   = 1'b0;
        errAtDone = 1'b0;
        for (int c = 1; c <= 300 && !gotDone; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                checkOutput($sformatf("job%0d.busy", idx), {31'h0, busy}, 32'h1);
                checkOutput($sformatf("job%0d.errClr", idx), {31'h0, error}, 32'h0);
            end
            if (j.midStart != 0 && c == j.midStart) begin
                start    = 1'b1;
                src_addr = 32'h0900_0000;
                dst_addr = 32'h0900_0100;
                len      = 16'd5;
            end else if (j.midStart != 0 && c == j.midStart + 1) begin
                start = 1'b0;
            end
            if (iomem_valid) validCnt++;
            if (done) begin
                gotDone   = 1'b1;
                lat       = c;
                errAtDone = error;
            end
        end
        start = 1'b0;
        checkOutput($sformatf("job%0d.doneLat", idx), lat, j.expLat);
        checkOutput($sformatf("job%0d.error", idx), {31'h0, errAtDone}, {31'h0, j.expErr});
        @(negedge clk);
        checkOutput($sformatf("job%0d.donePulse", idx), {31'h0, done}, 32'h0);
        checkOutput($sformatf("job%0d.idleBusy", idx), {31'h0, busy}, 32'h0);
        expValid = 2 * j.len * (j.waits + 1);
        checkOutput($sformatf("job%0d.validCycles", idx), validCnt, expValid);
        checkOutput($sformatf("job%0d.accCount", idx), accLog.size(), 2 * j.len);
        for (int k = 0; k < accLog.size() && k < 2 * j.len; k++) begin
            logic [31:0] sa;
            logic [31:0] da;
            sa = j.src + 32'(4 * (k / 2));
            da = j.dst + 32'(4 * (k / 2));
            checkOutput($sformatf("job%0d.acc%0d.addr", idx, k), accLog[k].addr, (k % 2 == 0) ? sa : da);
            checkOutput($sformatf("job%0d.acc%0d.wr", idx, k), {31'h0, accLog[k].wr}, (k % 2 == 0) ? 32'h0 : 32'h1);
            checkOutput($sformatf("job%0d.acc%0d.data", idx, k), accLog[k].data, pat(sa));
        end
        for (int w = 0; w < j.len; w++) begin
            checkOutput($sformatf("job%0d.mem%0d", idx, w),
                        readMem(j.dst + 32'(4 * w)), pat(j.src + 32'(4 * w)));
        end
    endtask

    initial begin : main
        job_t jobs[6];
        job_t rec;
        int   validCnt;
        int   lat;
        logic gotDone;
        logic errAtDone;
        logic sawDone;
        logic foundWr;

        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b1;
        start       = 1'b0;
        src_addr    = 32'h0;
        dst_addr    = 32'h0;
        len         = 16'h0;
        strayReady  = 1'b0;
        waits       = 0;
        neverReady  = 1'b0;

        // src, dst, len, waits, midStart cycle, expected done cycle, expected error
        jobs[0] = '{32'h0300_0000, 32'h0300_0100, 3, 0, 0, 13, 1'b0};
        jobs[1] = '{32'h0400_0000, 32'h0400_0200, 2, 5, 0, 29, 1'b0};
        jobs[2] = '{32'h0500_0000, 32'h0500_0100, 0, 0, 0,  2, 1'b0};
        jobs[3] = '{32'hFFFF_FFFC, 32'h0600_0000, 2, 0, 0,  9, 1'b0};
        jobs[4] = '{32'h0700_0000, 32'h0700_0100, 1, 8, 0, 21, 1'b0};
        jobs[5] = '{32'h0800_0000, 32'h0800_0100, 2, 0, 3,  9, 1'b0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.busy", {31'h0, busy}, 32'h0);
        checkOutput("rst.done", {31'h0, done}, 32'h0);
        checkOutput("rst.error", {31'h0, error}, 32'h0);
        checkOutput("rst.valid", {31'h0, iomem_valid}, 32'h0);
        checkOutput("rst.wstrb", {28'h0, iomem_wstrb}, 32'h0);
        checkOutput("rst.addr", iomem_addr, 32'h0);
        checkOutput("rst.wdata", iomem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Ready without valid in IDLE must do nothing.
        strayReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stray.busy", {31'h0, busy}, 32'h0);
            checkOutput("stray.valid", {31'h0, iomem_valid}, 32'h0);
        end
        strayReady = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i, jobs[i]);
            @(negedge clk);
        end

        // Responder never answers: abort after TIMEOUT stalled cycles.
        neverReady = 1'b1;
        accLog.delete();
        start     = 1'b1;
        src_addr  = 32'h0A00_0000;
        dst_addr  = 32'h0A00_0100;
        len       = 16'd1;
        validCnt  = 0;
        lat       = 0;
        gotDone   = 1'b0;
        errAtDone = 1'b0;
        for (int c = 1; c <= 60 && !gotDone; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (iomem_valid) validCnt++;
            if (done) begin
                gotDone   = 1'b1;
                lat       = c;
                errAtDone = error;
            end
        end
        checkOutput("tmo.validCycles", validCnt, TMO + 1);
        checkOutput("tmo.doneLat", lat, TMO + 2);
        checkOutput("tmo.errAtDone", {31'h0, errAtDone}, 32'h1);
        @(negedge clk);
        checkOutput("tmo.busy", {31'h0, busy}, 32'h0);
        checkOutput("tmo.errSticky", {31'h0, error}, 32'h1);
        checkOutput("tmo.donePulse", {31'h0, done}, 32'h0);
        checkOutput("tmo.accCount", accLog.size(), 0);
        neverReady = 1'b0;
        @(negedge clk);
        checkOutput("tmo.errHeld", {31'h0, error}, 32'h1);
        rec = '{32'h0C00_0000, 32'h0C00_0100, 1, 0, 0, 5, 1'b0};
        applyStimulus(6, rec);
        @(negedge clk);

        // Reset while a write is stalled on the bus.
        waits    = 3;
        accLog.delete();
        start    = 1'b1;
        src_addr = 32'h0B00_0000;
        dst_addr = 32'h0B00_0100;
        len      = 16'd2;
        foundWr  = 1'b0;
        for (int c = 1; c <= 40 && !foundWr; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (iomem_valid && iomem_wstrb == 4'hF) foundWr = 1'b1;
        end
        checkOutput("rstWr.reachedWr", {31'h0, foundWr}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstWr.valid", {31'h0, iomem_valid}, 32'h0);
        checkOutput("rstWr.busy", {31'h0, busy}, 32'h0);
        checkOutput("rstWr.done", {31'h0, done}, 32'h0);
        checkOutput("rstWr.addr", iomem_addr, 32'h0);
        checkOutput("rstWr.wstrb", {28'h0, iomem_wstrb}, 32'h0);
        reset   = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy || iomem_valid) sawDone = 1'b1;
        end
        checkOutput("rstWr.quietAfter", {31'h0, sawDone}, 32'h0);
        checkOutput("rstWr.noWrite", {31'h0, mem.exists(32'h0B00_0100)}, 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
